// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU opcodes, issue-stage state encodings
// and small decode helpers.
package alu_issue_stage_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int IMM_W_DEF = 8;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SRA = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_shift(
    input logic [2:0] op
  );
    return (op == ALU_SLL) ||
           (op == ALU_SRL) ||
           (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_stage_operand_cond.sv
// Operand-2 conditioning: immediate extension,
// reg/imm select, shift-amount masking.
module alu_issue_stage_operand_cond
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IMM_W = IMM_W_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] b,
  input  logic [IMM_W-1:0] imm,
  input  logic             use_imm,
  input  logic             imm_signed,
  output logic [WIDTH-1:0] b2
);

  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] opnd;
  logic             fill;

  // extend, select, then clamp shifts to 0..15
  always_comb begin
    fill = imm_signed & imm[IMM_W-1];
    ext  = {{(WIDTH-IMM_W){fill}}, imm};
    opnd = use_imm ? ext : b;
    b2   = opnd;
    unique case (1'b1)
      is_shift(op): b2 = {{(WIDTH-4){1'b0}}, opnd[3:0]};
      default:      b2 = opnd;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the ALU: holds operands
// for the ALU latency, captures result + flags.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int IMM_W       = IMM_W_DEF,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [IMM_W-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic             in_imm_signed,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [2:0]       out_op
);

  localparam int CW = $clog2(ALU_LATENCY + 2);
  localparam int MSB = WIDTH - 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b2;
  logic             ovf;

  assign in_ready = (state == ST_IDLE);

  alu_issue_stage_operand_cond #(
    .WIDTH (WIDTH),
    .IMM_W (IMM_W)
  ) u_cond (
    .op         (in_op),
    .b          (in_b),
    .imm        (in_imm),
    .use_imm    (in_use_imm),
    .imm_signed (in_imm_signed),
    .b2         (b2)
  );

  // signed overflow from held operands + result
  always_comb begin
    ovf = 1'b0;
    unique case (1'b1)
      alu_control == ALU_ADD:
        ovf = (alu_in1[MSB] == alu_in2[MSB]) &&
              (alu_result[MSB] != alu_in1[MSB]);
      alu_control == ALU_SUB:
        ovf = (alu_in1[MSB] != alu_in2[MSB]) &&
              (alu_result[MSB] != alu_in1[MSB]);
      default:
        ovf = 1'b0;
    endcase
  end

  // handshake FSM, latency count, result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_control  <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_op       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            alu_in1     <= in_a;
            alu_in2     <= b2;
            alu_control <= in_op;
            cnt         <= CW'(ALU_LATENCY);
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            out_result   <= alu_result;
            out_zero     <= (alu_result == '0);
            out_overflow <= ovf;
            out_op       <= alu_control;
            out_valid    <= 1'b1;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a one-cycle
// registered ALU and an in-order scoreboard.
module tb_alu_issue_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [7:0]  in_imm;
  logic        in_use_imm;
  logic        in_imm_signed;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [2:0]  alu_control;
  logic [15:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic [2:0]  out_op;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  imm;
    logic        use_imm;
    logic        imm_signed;
    logic [15:0] exp_in2;
    logic [15:0] exp_res;
    logic        exp_zero;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        zero;
    logic        ovf;
    logic [2:0]  op;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[13];

  alu_issue_stage #(
    .WIDTH       (16),
    .IMM_W       (8),
    .ALU_LATENCY (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_imm        (in_imm),
    .in_use_imm    (in_use_imm),
    .in_imm_signed (in_imm_signed),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_control   (alu_control),
    .alu_result    (alu_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_overflow  (out_overflow),
    .out_op        (out_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // one-cycle registered ALU stand-in
  always @(posedge clock) begin
    case (alu_control)
      3'd0: alu_result <= alu_in1 & alu_in2;
      3'd1: alu_result <= alu_in1 | alu_in2;
      3'd2: alu_result <= alu_in1 + alu_in2;
      3'd3: alu_result <= alu_in1 - alu_in2;
      3'd4: alu_result <= alu_in1 << alu_in2[3:0];
      3'd5: alu_result <= alu_in1 >> alu_in2[3:0];
      3'd6: alu_result <=
        $signed(alu_in1) >>> alu_in2[3:0];
      default: alu_result <=
        {15'd0, $signed(alu_in1) < $signed(alu_in2)};
    endcase
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  // scoreboard: pop on each output handshake
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(out_result),
            32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("out_result", 32'(out_result),
            32'(mon_e.res));
        chk("out_zero", 32'(out_zero),
            32'(mon_e.zero));
        chk("out_overflow", 32'(out_overflow),
            32'(mon_e.ovf));
        chk("out_op", 32'(out_op), 32'(mon_e.op));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    in_op         = v.op;
    in_a          = v.a;
    in_b          = v.b;
    in_imm        = v.imm;
    in_use_imm    = v.use_imm;
    in_imm_signed = v.imm_signed;
    in_valid      = 1'b1;
  endtask

  task automatic push(input vec_t v);
    sb.push_back('{v.exp_res, v.exp_zero,
                   v.exp_ovf, v.op});
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 10) begin
      step();
      k++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    wait_ready();
    drive(v);
    push(v);
    step();
    in_valid = 1'b0;
    chk("alu_in1", 32'(alu_in1), 32'(v.a));
    chk("alu_in2", 32'(alu_in2), 32'(v.exp_in2));
    chk("alu_control", 32'(alu_control),
        32'(v.op));
    chk("valid_early", 32'(out_valid), 32'd0);
    wait_out(k);
    chk("latency", 32'(k), 32'd2);
    step();
  endtask

  vec_t va;
  vec_t vb;
  vec_t vr;
  int   k2;
  bit   rose;

  initial begin
    vecs[0]  = '{3'd2, 16'h7FFF, 16'h0001, 8'h00,
                 0, 0, 16'h0001, 16'h8000, 0, 1};
    vecs[1]  = '{3'd3, 16'h0005, 16'h0000, 8'hFB,
                 1, 1, 16'hFFFB, 16'h000A, 0, 0};
    vecs[2]  = '{3'd3, 16'h0005, 16'h0000, 8'hFB,
                 1, 0, 16'h00FB, 16'hFF0A, 0, 0};
    vecs[3]  = '{3'd4, 16'h0001, 16'h001F, 8'h00,
                 0, 0, 16'h000F, 16'h8000, 0, 0};
    vecs[4]  = '{3'd7, 16'h0001, 16'hFFFF, 8'h00,
                 0, 0, 16'hFFFF, 16'h0000, 1, 0};
    vecs[5]  = '{3'd0, 16'hF0F0, 16'h0F0F, 8'h00,
                 0, 0, 16'h0F0F, 16'h0000, 1, 0};
    vecs[6]  = '{3'd1, 16'h1200, 16'h0034, 8'h00,
                 0, 0, 16'h0034, 16'h1234, 0, 0};
    vecs[7]  = '{3'd5, 16'h8000, 16'h0000, 8'h24,
                 1, 0, 16'h0004, 16'h0800, 0, 0};
    vecs[8]  = '{3'd6, 16'h8000, 16'h0003, 8'h00,
                 0, 0, 16'h0003, 16'hF000, 0, 0};
    vecs[9]  = '{3'd3, 16'h8000, 16'h0001, 8'h00,
                 0, 0, 16'h0001, 16'h7FFF, 0, 1};
    vecs[10] = '{3'd2, 16'h8000, 16'h8000, 8'h00,
                 0, 0, 16'h8000, 16'h0000, 1, 1};
    vecs[11] = '{3'd7, 16'hFFFF, 16'h0001, 8'h00,
                 0, 0, 16'h0001, 16'h0001, 0, 0};
    vecs[12] = '{3'd2, 16'h0003, 16'h0000, 8'h80,
                 1, 1, 16'hFF80, 16'hFF83, 0, 0};

    reset         = 1'b1;
    in_valid      = 1'b0;
    in_op         = '0;
    in_a          = '0;
    in_b          = '0;
    in_imm        = '0;
    in_use_imm    = 1'b0;
    in_imm_signed = 1'b0;
    out_ready     = 1'b1;

    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_in1", 32'(alu_in1), 32'd0);
    chk("rst_alu_in2", 32'(alu_in2), 32'd0);
    chk("rst_alu_ctl", 32'(alu_control), 32'd0);
    chk("rst_out_res", 32'(out_result), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_ovf", 32'(out_overflow), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
    end

    va = '{3'd2, 16'h0002, 16'h0003, 8'h00,
           0, 0, 16'h0003, 16'h0005, 0, 0};
    vb = '{3'd3, 16'h000A, 16'h0004, 8'h00,
           0, 0, 16'h0004, 16'h0006, 0, 0};
    out_ready = 1'b0;
    wait_ready();
    drive(va);
    push(va);
    step();
    in_valid = 1'b0;
    wait_out(k2);
    chk("bp_latency", 32'(k2), 32'd2);
    drive(vb);
    push(vb);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(out_result), 32'h5);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_alu_in1", 32'(alu_in1), 32'h2);
      chk("bp_alu_in2", 32'(alu_in2), 32'h3);
    end
    out_ready = 1'b1;
    step();
    chk("rel_valid", 32'(out_valid), 32'd0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_no_accept", 32'(alu_in1), 32'h2);
    step();
    in_valid = 1'b0;
    chk("b_alu_in1", 32'(alu_in1), 32'hA);
    chk("b_alu_in2", 32'(alu_in2), 32'h4);
    wait_out(k2);
    chk("b_latency", 32'(k2), 32'd2);
    step();

    vr = '{3'd2, 16'h0001, 16'h0001, 8'h00,
           0, 0, 16'h0001, 16'h0002, 0, 0};
    wait_ready();
    drive(vr);
    step();
    in_valid = 1'b0;
    step();
    chk("mid_wait_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) rose = 1'b1;
    end
    chk("mid_rst_no_out", 32'(rose), 32'd0);
    run_vec(vecs[0]);
    run_vec(vecs[3]);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
